// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] DEF_RESET_VEC = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

endpackage

// File: rtl/add16_nc.sv
// 16-bit ripple adder with carry-in and no carry-out.
module add16_nc
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] A,
    input  logic [PC_W-1:0] B,
    input  logic            I,
    output logic [PC_W-1:0] S
);

    logic [PC_W-1:0] c;

    assign c[0] = I;

    for (genvar i = 0; i < PC_W - 1; i++) begin : g_cell
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    // Cap cell: top bit sum only, carry-out deliberately dropped.
    assign S[PC_W-1] = A[PC_W-1] ^ B[PC_W-1] ^ c[PC_W-1];

endmodule

// File: rtl/pc_sequencer.sv
// PC stage with boot/run/halt control feeding the fetch adder.
// Define PC_SEQ_WRAP_TRAP_EN to trap and halt on increment wrap.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC   = DEF_RESET_VEC,
    parameter int unsigned     BOOT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            halt,
    input  logic            resume,
    input  logic            stall,
    input  logic            brEn,
    input  logic [PC_W-1:0] brOff,
    input  logic            jmpEn,
    input  logic [PC_W-1:0] jmpAddr,
    output logic [PC_W-1:0] pc,
    output logic            pcValid,
    output logic [PC_W-1:0] retAddr,
    output logic            halted,
    output logic            trap
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] add_b;
    logic            add_ci;
    logic            take_br;

    assign take_br = (state_q == ST_RUN) && !halt && !jmpEn && brEn;
    assign add_b   = take_br ? brOff : '0;
    assign add_ci  = !take_br;

    add16_nc u_next_add (
        .A (pc_q),
        .B (add_b),
        .I (add_ci),
        .S (pc_d)
    );

    add16_nc u_ret_add (
        .A (pc_q),
        .B ('0),
        .I (1'b1),
        .S (retAddr)
    );

`ifdef PC_SEQ_WRAP_TRAP_EN
    logic trap_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
            cnt_q   <= BOOT_INIT;
            pc_q    <= RESET_VEC;
`ifdef PC_SEQ_WRAP_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (cnt_q == '0) state_q <= ST_RUN;
                    else cnt_q <= cnt_q - 4'd1;
                end
                ST_RUN: begin
                    if (halt) begin
                        state_q <= ST_HALT;
                    end else if (jmpEn) begin
                        pc_q <= jmpAddr;
                    end else if (brEn) begin
                        pc_q <= pc_d;
                    end else if (!stall) begin
                        pc_q <= pc_d;
`ifdef PC_SEQ_WRAP_TRAP_EN
                        if (pc_q == '1) begin
                            trap_q  <= 1'b1;
                            state_q <= ST_HALT;
                        end
`endif
                    end
                end
                ST_HALT: begin
                    if (resume && !halt) state_q <= ST_RUN;
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign pc      = pc_q;
    assign pcValid = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALT);

`ifdef PC_SEQ_WRAP_TRAP_EN
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

    localparam logic [15:0] RVEC  = 16'h0100;
    localparam int          BOOTN = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        halt, resume, stall, brEn, jmpEn;
    logic [15:0] brOff, jmpAddr;
    logic [15:0] pc, retAddr;
    logic        pcValid, halted, trap;

    pc_sequencer #(
        .RESET_VEC   (RVEC),
        .BOOT_CYCLES (BOOTN)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .halt    (halt),
        .resume  (resume),
        .stall   (stall),
        .brEn    (brEn),
        .brOff   (brOff),
        .jmpEn   (jmpEn),
        .jmpAddr (jmpAddr),
        .pc      (pc),
        .pcValid (pcValid),
        .retAddr (retAddr),
        .halted  (halted),
        .trap    (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        v;
        logic [15:0] ra;
        logic        h;
        logic        t;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Behavioural model: boot cycles left, halted flag, pc, sticky trap.
    int          m_boot;
    bit          m_halt;
    bit          m_trap;
    logic [15:0] m_pc;

    function automatic void model_reset();
        m_boot = BOOTN;
        m_halt = 0;
        m_trap = 0;
        m_pc   = RVEC;
    endfunction

    function automatic void model_edge();
        if (m_boot > 0) begin
            m_boot--;
        end else if (m_halt) begin
            if (resume && !halt) m_halt = 0;
        end else if (halt) begin
            m_halt = 1;
        end else if (jmpEn) begin
            m_pc = jmpAddr;
        end else if (brEn) begin
            m_pc = 16'((int'(m_pc) + int'(brOff)) % 65536);
        end else if (!stall) begin
`ifdef PC_SEQ_WRAP_TRAP_EN
            if (m_pc == 16'hFFFF) begin
                m_trap = 1;
                m_halt = 1;
            end
`endif
            m_pc = 16'((int'(m_pc) + 1) % 65536);
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.pc = m_pc;
        e.v  = (m_boot == 0) && !m_halt;
        e.ra = 16'((int'(m_pc) + 1) % 65536);
        e.h  = m_halt;
        e.t  = m_trap;
        return e;
    endfunction

    task automatic step(input logic nh, input logic nr, input logic ns,
                        input logic nbe, input logic [15:0] nbo,
                        input logic nje, input logic [15:0] nja,
                        input logic nrst);
        @(posedge clk);
        #1;
        if (rstn) model_edge();
        halt    = nh;
        resume  = nr;
        stall   = ns;
        brEn    = nbe;
        brOff   = nbo;
        jmpEn   = nje;
        jmpAddr = nja;
        rstn    = nrst;
        if (!nrst) model_reset();
        q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    endtask

    task automatic jmp(input logic [15:0] a);
        step(0, 0, 0, 0, 16'h0, 1, a, 1);
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("pcValid", 16'(pcValid), 16'(e.v));
                chk("retAddr", retAddr, e.ra);
                chk("halted", 16'(halted), 16'(e.h));
                chk("trap", 16'(trap), 16'(e.t));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 0; halt = 0; resume = 0; stall = 0;
        brEn = 0; jmpEn = 0; brOff = '0; jmpAddr = '0;
        model_reset();
        step(0, 0, 0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 0, 0, 16'h0, 0, 16'h0, 1);
        idle(5);

        jmp(16'h0010);
        step(0, 0, 0, 1, 16'hFFF0, 0, 16'h0, 1);
        step(0, 0, 0, 1, 16'h0005, 0, 16'h0, 1);
        idle(1);

        step(0, 0, 1, 1, 16'h0033, 1, 16'h4000, 1);
        step(0, 0, 1, 0, 16'h0, 0, 16'h0, 1);
        step(0, 0, 1, 1, 16'h0010, 0, 16'h0, 1);
        idle(1);

        jmp(16'h0020);
        step(1, 0, 0, 1, 16'h0008, 1, 16'h7777, 1);
        step(1, 0, 0, 1, 16'h0008, 1, 16'h7777, 1);
        step(1, 1, 0, 0, 16'h0, 0, 16'h0, 1);
        step(0, 0, 0, 0, 16'h0, 0, 16'h0, 1);
        step(0, 1, 0, 0, 16'h0, 0, 16'h0, 1);
        idle(3);

        jmp(16'hFFFF);
        idle(3);
        step(0, 1, 0, 0, 16'h0, 0, 16'h0, 1);
        idle(2);

        jmp(16'h1234);
        step(0, 0, 0, 1, 16'h0100, 0, 16'h0, 0);
        step(0, 0, 0, 0, 16'h0, 0, 16'h0, 1);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ja;
            ja = ($urandom % 4 == 0) ? (16'hFFF0 | 16'($urandom % 16))
                                     : 16'($urandom);
            step($urandom % 16 == 0, $urandom % 4 == 0, $urandom % 4 == 0,
                 $urandom % 6 == 0, 16'($urandom), $urandom % 8 == 0, ja,
                 !($urandom % 200 == 0));
        end

        @(negedge clk);
        #1;
        chk("drain", 16'(q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly upstream of the fetch address adder.
- Holds the 16-bit PC, selects the next-PC source (increment, PC-relative branch, absolute jump, hold) and drives the operands and carry-in of a 16-bit no-carry-out adder.
- Registers the adder's sum as the next PC.
- Provides a boot/halt state machine and a valid-qualified fetch address to the instruction memory interface.

Parameters:
- RESET_VEC, 16'h0000, PC value loaded on reset.
- BOOT_CYCLES, 2, cycles after reset release with pcValid held low (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- halt  in  1  request to stop fetching; level-sensitive.
- resume  in  1  single-cycle pulse; leaves HALT.
- stall  in  1  hold PC this cycle (downstream not ready).
- brEn  in  1  take PC-relative branch this cycle.
- brOff  in  16  two's-complement word offset, added to current PC.
- jmpEn  in  1  take absolute jump this cycle.
- jmpAddr  in  16  absolute jump target.
- pc  out  16  current fetch address.
- pcValid  out  1  pc is a valid fetch request this cycle.
- retAddr  out  16  pc + 1, combinational; link value for calls.
- halted  out  1  state is HALT.
- trap  out  1  wrap trap flag; only with the optional feature, else tied 0.

Behaviour:
- Reset (rstn low, asynchronous): pc = RESET_VEC, state = BOOT, boot counter = BOOT_CYCLES-1, pcValid = 0, halted = 0, trap = 0. Reset asserted mid-operation discards any pending branch/jump.
- BOOT: counter decrements each cycle; pc is held. At counter == 0, go to RUN. No inputs are sampled in BOOT.
- RUN: pcValid = 1. Next-PC priority, highest first:
  - halt: go to HALT, pc held.
  - jmpEn: pc <= jmpAddr; adder bypassed.
  - brEn: pc <= pc + brOff.
  - stall: pc held.
  - otherwise: pc <= pc + 1.
- Branch/jump beat stall: a redirect always commits in the cycle it is presented, even with stall high.
- HALT: pcValid = 0, halted = 1, pc frozen. The resume pulse returns to RUN on the next edge. If halt is still high when resume arrives, stay in HALT; resume wins only when halt is low. brEn/jmpEn are ignored in HALT.
- Adder use:
  - Increment drives A = pc, B = 16'h0000, carry-in = 1.
  - Branch drives A = pc, B = brOff, carry-in = 0.
  - retAddr uses a second adder instance with A = pc, B = 0, carry-in = 1.
- Arithmetic is modulo 2^16 with no carry-out: 16'hFFFF + 1 = 16'h0000; pc + 16'hFFFF (-1) = pc - 1.
- Latency: a redirect presented in cycle N appears on pc in cycle N+1. pcValid tracks state combinationally from the registered state.

Optional Feature:
- Macro: PC_SEQ_WRAP_TRAP_EN.
- Defined: when an increment (not a jump or branch) advances pc from 16'hFFFF, pc still becomes 16'h0000. On that edge:
  - trap is set and stays sticky until reset;
  - state is forced to HALT.
- resume does not clear trap. Resume from this HALT is allowed and continues from 16'h0000.
- Not defined: wrap is silent and trap is a constant 0.

Decomposition:
- Shared package/header:
  - state encodings BOOT = 2'b00, RUN = 2'b01, HALT = 2'b10;
  - PC width constant 16;
  - default RESET_VEC.
- One natural sub-module: add16_nc, a 16-bit no-carry-out adder with A, B, I, S ports, built as 15 carry-out one-bit cells plus a one-bit cap cell. Instantiated twice (next-PC and retAddr).

Test Plan:
- Reset, BOOT_CYCLES=2, RESET_VEC=16'h0100 -> pcValid 0 for 2 cycles, then pc 0x0100, 0x0101, 0x0102 with pcValid 1.
- RUN at pc 0x0010, brEn with brOff 16'hFFF0 (-16) -> next pc 0x0000. Then brOff 16'h0005 -> pc 0x0005.
- jmpEn (jmpAddr 0x4000) and brEn together with stall high -> next pc 0x4000 (jump beats branch and stall).
- halt at pc 0x0020 -> halted 1, pcValid 0, pc stays 0x0020. resume while halt high -> still HALT. halt low + resume -> pc 0x0021 next cycle.
- pc 0xFFFF increment -> pc 0x0000; with PC_SEQ_WRAP_TRAP_EN: trap 1, halted 1; without: trap 0, continues 0x0001.
- rstn pulsed low mid-branch at pc 0x1234 -> immediately pc = RESET_VEC, pcValid 0, trap 0, no branch committed.
